// File: rtl/branch_pkg.sv
// Shared types and constants for the branch predictor loop: queued entry
// layout, default index width and the 2-bit saturating predictor encodings.
package branch_pkg;

   localparam int BR_IDX_W = 4;

   typedef struct packed {
      logic                taken;
      logic [BR_IDX_W-1:0] idx;
   } br_entry_t;

   localparam logic [1:0] PRED_SNT = 2'b00;
   localparam logic [1:0] PRED_WNT = 2'b01;
   localparam logic [1:0] PRED_WT  = 2'b10;
   localparam logic [1:0] PRED_ST  = 2'b11;

endpackage

// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute side of the branch resolve queue: prediction push, resolve
// request, predictor update and statistics.
interface branch_resolve_queue_if #(
   parameter int DEPTH = 4,
   parameter int IDX_W = 4,
   parameter int CNT_W = 16
);
   localparam int CW = $clog2(DEPTH + 1);

   logic             pred_valid;
   logic             pred_ready;
   logic             pred_taken;
   logic [IDX_W-1:0] pred_idx;
   logic             res_valid;
   logic             res_taken;
   logic             upd_valid;
   logic             upd_taken;
   logic [IDX_W-1:0] upd_idx;
   logic             mispredict;
   logic             res_err;
   logic [CW-1:0]    count;
   logic [CNT_W-1:0] br_cnt;
   logic [CNT_W-1:0] misp_cnt;

   modport master (
      output pred_valid, pred_taken, pred_idx, res_valid, res_taken,
      input  pred_ready, upd_valid, upd_taken, upd_idx, mispredict,
             res_err, count, br_cnt, misp_cnt
   );

   modport slave (
      input  pred_valid, pred_taken, pred_idx, res_valid, res_taken,
      output pred_ready, upd_valid, upd_taken, upd_idx, mispredict,
             res_err, count, br_cnt, misp_cnt
   );

endinterface

// File: rtl/branch_fifo.sv
// Circular buffer of in-flight branch entries with push/pop and a
// whole-queue clear that takes priority over both.
module branch_fifo
   import branch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = BR_IDX_W + 1,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic          clear_i,
   input  logic [W-1:0]  wdata_i,
   output logic [W-1:0]  rdata_o,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          empty_o
);

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // Clear wins: a flushed cycle neither stores nor retires anything.
   assign do_push = push_i && !full_o && !clear_i;
   assign do_pop  = pop_i && !empty_o && !clear_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/branch_resolve_queue.sv
// Queues fetch-time predictions, checks them against execute outcomes and
// produces registered predictor updates, mispredict flushes and statistics.
module branch_resolve_queue
   import branch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int IDX_W = BR_IDX_W,
   parameter int CNT_W = 16
) (
   input logic              clk,
   input logic              reset,
   branch_resolve_queue_if.slave bus
);

   localparam int CW = $clog2(DEPTH + 1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   logic [IDX_W:0]   head;
   logic             head_taken;
   logic [IDX_W-1:0] head_idx;
   logic             fifo_full, fifo_empty;
   logic [CW-1:0]    fifo_count;
   logic             res_ok, misp;

   logic             upd_valid_q, upd_valid_d;
   logic             upd_taken_q, upd_taken_d;
   logic [IDX_W-1:0] upd_idx_q, upd_idx_d;
   logic             misp_q, misp_d;
   logic             res_err_q, res_err_d;
   logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0] misp_cnt_q, misp_cnt_d;

   assign head_taken = head[IDX_W];
   assign head_idx   = head[IDX_W-1:0];
   assign res_ok     = bus.res_valid && !fifo_empty;
   assign misp       = res_ok && (head_taken != bus.res_taken);

   // A mispredict flushes everything younger, including this cycle's push.
   branch_fifo #(
      .DEPTH (DEPTH),
      .W     (IDX_W + 1)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (bus.pred_valid),
      .pop_i   (res_ok && !misp),
      .clear_i (misp),
      .wdata_i ({bus.pred_taken, bus.pred_idx}),
      .rdata_o (head),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      upd_valid_d = res_ok;
      upd_taken_d = upd_taken_q;
      upd_idx_d   = upd_idx_q;
      misp_d      = misp;
      res_err_d   = bus.res_valid && fifo_empty;
      br_cnt_d    = br_cnt_q;
      misp_cnt_d  = misp_cnt_q;
      if (res_ok) begin
         upd_taken_d = bus.res_taken;
         upd_idx_d   = head_idx;
         br_cnt_d    = sat_inc(br_cnt_q);
      end
      if (misp) misp_cnt_d = sat_inc(misp_cnt_q);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         upd_valid_q <= 1'b0;
         upd_taken_q <= 1'b0;
         upd_idx_q   <= '0;
         misp_q      <= 1'b0;
         res_err_q   <= 1'b0;
         br_cnt_q    <= '0;
         misp_cnt_q  <= '0;
      end else begin
         upd_valid_q <= upd_valid_d;
         upd_taken_q <= upd_taken_d;
         upd_idx_q   <= upd_idx_d;
         misp_q      <= misp_d;
         res_err_q   <= res_err_d;
         br_cnt_q    <= br_cnt_d;
         misp_cnt_q  <= misp_cnt_d;
      end
   end

   assign bus.pred_ready = !fifo_full;
   assign bus.count      = fifo_count;
   assign bus.upd_valid  = upd_valid_q;
   assign bus.upd_taken  = upd_taken_q;
   assign bus.upd_idx    = upd_idx_q;
   assign bus.mispredict = misp_q;
   assign bus.res_err    = res_err_q;
   assign bus.br_cnt     = br_cnt_q;
   assign bus.misp_cnt   = misp_cnt_q;

endmodule
